// File: rtl/iq_sample_packer_if.sv
// Stream bundle for iq_sample_packer: 32-bit IQ sample input stream and packed output stream.
// Parameters must match the packer instance so that o_nsamp has the same width.
//   i_tdata/i_tvalid/i_tlast/i_tready : sample stream into the packer
//   o_tdata/o_tvalid/o_tlast/o_nsamp/o_tready : packed word stream out of the packer
// Modports: slave is the packer's view, master is the view of whoever drives the samples
// and consumes the packed words.
interface iq_sample_packer_if #(
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned OUT_BITS  = 4
);
  localparam int unsigned NsW = $clog2(OUT_WIDTH / (2 * OUT_BITS) + 1);

  logic [31:0]          i_tdata;
  logic                 i_tvalid;
  logic                 i_tlast;
  logic                 i_tready;
  logic [OUT_WIDTH-1:0] o_tdata;
  logic                 o_tvalid;
  logic                 o_tlast;
  logic [NsW-1:0]       o_nsamp;
  logic                 o_tready;

  modport slave (
    input  i_tdata, i_tvalid, i_tlast, o_tready,
    output i_tready, o_tdata, o_tvalid, o_tlast, o_nsamp
  );

  modport master (
    output i_tdata, i_tvalid, i_tlast, o_tready,
    input  i_tready, o_tdata, o_tvalid, o_tlast, o_nsamp
  );
endinterface

// File: rtl/iq_sample_packer.sv
// IQ sample compressor: reduces each 16-bit I/Q component to OUT_BITS bits (truncate, or
// round half-up with positive saturation) and packs N = OUT_WIDTH/(2*OUT_BITS) samples per
// output word, first sample in the most significant slot. A tlast beat flushes a partial,
// zero-padded word; packets never share a word.
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   io_bus : slave side of iq_sample_packer_if (sample stream in, packed word stream out,
//            o_nsamp = number of valid slots in o_tdata)
module iq_sample_packer #(
  parameter int unsigned OUT_BITS  = 4,
  parameter int unsigned OUT_WIDTH = 32,
  parameter bit          ROUND     = 1'b0
) (
  input logic              clk,
  input logic              reset,
  iq_sample_packer_if.slave io_bus
);
  localparam int unsigned SlotW = 2 * OUT_BITS;
  localparam int unsigned N     = OUT_WIDTH / SlotW;
  localparam int unsigned CntW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NsW   = $clog2(N + 1);

  // Reduce one 16-bit two's-complement component to OUT_BITS bits.
  function automatic logic [OUT_BITS-1:0] f_reduce(input logic [15:0] x);
    logic [16:0]         s;
    logic [OUT_BITS-1:0] r;
    s = {x[15], x} + (17'd1 << (15 - OUT_BITS));
    if (ROUND == 1'b0) begin
      r = x[15 -: OUT_BITS];
    end else if (!x[15] && s[15]) begin
      // Positive input carried into the sign bit: clamp to the largest positive code.
      r = {OUT_BITS{1'b1}} >> 1;
    end else begin
      r = OUT_BITS'(s >> (16 - OUT_BITS));
    end
    return r;
  endfunction

  logic [OUT_WIDTH-1:0] r_acc;
  logic [CntW-1:0]      r_cnt;
  logic [OUT_WIDTH-1:0] r_odata;
  logic                 r_tvalid;
  logic                 r_tlast;
  logic [NsW-1:0]       r_nsamp;

  logic [OUT_BITS-1:0]  w_i_red;
  logic [OUT_BITS-1:0]  w_q_red;
  logic [SlotW-1:0]     w_slot;
  logic [OUT_WIDTH-1:0] w_slot_top;
  logic [31:0]          w_shamt;
  logic [OUT_WIDTH-1:0] w_acc_new;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_cnt_last;
  logic                 w_complete;
  logic [NsW-1:0]       w_nsamp;

  assign w_i_red    = f_reduce(io_bus.i_tdata[31:16]);
  assign w_q_red    = f_reduce(io_bus.i_tdata[15:0]);
  assign w_slot     = {w_i_red, w_q_red};

  // Slot 0 sits at the top of the word; later slots move down by SlotW each.
  assign w_slot_top = OUT_WIDTH'(w_slot) << (OUT_WIDTH - SlotW);
  assign w_shamt    = SlotW * 32'(r_cnt);
  // Slots below cnt are still zero because the accumulator clears on every completion,
  // so a flushed partial word is zero-padded without an explicit mask.
  assign w_acc_new  = r_acc | (w_slot_top >> w_shamt);

  // Throttle on the output register only; no combinational path from i_tvalid.
  assign w_ready    = ~r_tvalid | io_bus.o_tready;
  assign w_accept   = io_bus.i_tvalid & w_ready;
  assign w_cnt_last = (r_cnt == CntW'(N - 1));
  assign w_complete = w_accept & (w_cnt_last | io_bus.i_tlast);
  assign w_nsamp    = NsW'(r_cnt) + NsW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_odata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_nsamp  <= '0;
    end else begin
      if (w_accept) begin
        if (w_complete) begin
          r_acc   <= '0;
          r_cnt   <= '0;
          r_odata <= w_acc_new;
          r_tlast <= io_bus.i_tlast;
          r_nsamp <= w_nsamp;
        end else begin
          r_acc <= w_acc_new;
          r_cnt <= r_cnt + CntW'(1);
        end
      end
      // A load in the same cycle as a drain keeps o_tvalid high (back-to-back words).
      if (w_complete) begin
        r_tvalid <= 1'b1;
      end else if (io_bus.o_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign io_bus.i_tready = w_ready;
  assign io_bus.o_tdata  = r_odata;
  assign io_bus.o_tvalid = r_tvalid;
  assign io_bus.o_tlast  = r_tlast;
  assign io_bus.o_nsamp  = r_nsamp;
endmodule

// File: tb/tb_iq_sample_packer.sv
// Self-checking bench for iq_sample_packer: directed vector table (truncation, rounding,
// partial flush, single-sample packets), backpressure hold and streaming, asynchronous reset
// mid-word, and randomized packet sweeps over OUT_BITS = 1, 2, 4, 8 against a reference
// reduction model and a sample scoreboard.
module tb_iq_sample_packer;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   sweep_go = 1'b0;

  always #5 clk = ~clk;

  iq_sample_packer_if #(.OUT_WIDTH(32), .OUT_BITS(4)) ifa ();
  iq_sample_packer_if #(.OUT_WIDTH(32), .OUT_BITS(4)) ifb ();

  iq_sample_packer #(.OUT_BITS(4), .OUT_WIDTH(32), .ROUND(1'b0)) u_dut_trunc (
    .clk   (clk),
    .reset (reset),
    .io_bus(ifa.slave)
  );

  iq_sample_packer #(.OUT_BITS(4), .OUT_WIDTH(32), .ROUND(1'b1)) u_dut_round (
    .clk   (clk),
    .reset (reset),
    .io_bus(ifb.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_reduce(input logic [15:0] x, input int ob, input bit rnd);
    int v, maxp, r;
    v    = int'($signed(x));
    maxp = (1 << (ob - 1)) - 1;
    if (!rnd) begin
      r = v >>> (16 - ob);
    end else begin
      r = (v + (1 << (15 - ob))) >>> (16 - ob);
      if (r > maxp) r = maxp;
    end
    return r & ((1 << ob) - 1);
  endfunction

  // Backpressure stream sample k: I top nibble = k, Q top nibble = ~k.
  function automatic logic [31:0] bp_sample(input int k);
    logic [3:0] kk;
    kk = 4'(k);
    return {kk, 12'h000, ~kk, 12'h000};
  endfunction

  function automatic logic [31:0] bp_word(input int j);
    logic [31:0] w;
    logic [3:0]  kk;
    w = '0;
    for (int s = 0; s < 4; s++) begin
      kk = 4'(4 * j + s);
      w  = {w[23:0], kk, ~kk};
    end
    return w;
  endfunction

  typedef struct {
    bit          rnd;
    logic [31:0] d;
    bit          last;
    bit          chk;
    logic [31:0] w;
    logic [2:0]  ns;
    bit          ol;
  } vec_t;

  vec_t vecs[16];

  // Randomized sweeps, one DUT per OUT_BITS value.
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int unsigned OB  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 8;
    localparam bit          RND = (g == 1) || (g == 3);
    localparam int unsigned NS  = 32 / (2 * OB);

    iq_sample_packer_if #(.OUT_WIDTH(32), .OUT_BITS(OB)) sif ();

    iq_sample_packer #(.OUT_BITS(OB), .OUT_WIDTH(32), .ROUND(RND)) u_dut (
      .clk   (clk),
      .reset (reset),
      .io_bus(sif.slave)
    );

    logic [15:0] exp_q[$];
    int          tl_in  = 0;
    int          tl_out = 0;
    bit          done   = 1'b0;

    initial begin : drv
      int          len, budget, ri, rq;
      logic [31:0] d;
      bit          rdy;
      sif.i_tdata  = '0;
      sif.i_tvalid = 1'b0;
      sif.i_tlast  = 1'b0;
      wait (sweep_go);
      step();
      for (int p = 0; p < 6; p++) begin
        len = $urandom_range(1, 40);
        for (int s = 0; s < len; s++) begin
          if ($urandom_range(0, 4) == 0) begin
            sif.i_tvalid = 1'b0;
            step();
          end
          d            = $urandom;
          sif.i_tdata  = d;
          sif.i_tvalid = 1'b1;
          sif.i_tlast  = (s == len - 1);
          budget       = 0;
          do begin
            @(negedge clk);
            rdy = sif.i_tready;
            step();
            budget++;
          end while (!rdy && budget < 200);
          if (!rdy) check($sformatf("sweep%0d_accept_timeout", OB), 0, 1);
          ri = ref_reduce(d[31:16], OB, RND);
          rq = ref_reduce(d[15:0], OB, RND);
          exp_q.push_back(16'((ri << OB) | rq));
          if (s == len - 1) tl_in++;
        end
      end
      sif.i_tvalid = 1'b0;
      sif.i_tlast  = 1'b0;
      budget = 0;
      while (exp_q.size() != 0 && budget < 3000) begin
        step();
        budget++;
      end
      check($sformatf("sweep%0d_drain", OB), exp_q.size(), 0);
      check($sformatf("sweep%0d_tlast_count", OB), tl_out, tl_in);
      done = 1'b1;
    end

    initial begin : rdy_gen
      sif.o_tready = 1'b1;
      wait (sweep_go);
      while (!done) begin
        step();
        sif.o_tready = ($urandom_range(0, 3) != 0);
      end
      sif.o_tready = 1'b1;
    end

    always @(negedge clk) begin : mon
      int          n;
      logic [15:0] slot;
      logic [15:0] e;
      if (sif.o_tvalid && sif.o_tready) begin
        n = int'(sif.o_nsamp);
        check($sformatf("sweep%0d_nsamp_range", OB),
              (n >= 1 && n <= NS && (sif.o_tlast || n == NS)), 1);
        for (int k = 0; k < NS; k++) begin
          slot = 16'(sif.o_tdata[31 - 2 * OB * k -: 2 * OB]);
          if (k < n) begin
            if (exp_q.size() == 0) begin
              check($sformatf("sweep%0d_extra_sample", OB), slot, 16'hDEAD);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("sweep%0d_slot%0d", OB, k), slot, e);
            end
          end else begin
            check($sformatf("sweep%0d_pad%0d", OB, k), slot, 0);
          end
        end
        if (sif.o_tlast) tl_out++;
      end
    end
  end

  initial begin : main
    logic [31:0] got_w[$];
    int          got_c[$];
    bit          got_l[$];
    logic [2:0]  got_n[$];
    int          k, budget;
    bit          all_done;

    ifa.i_tdata = '0; ifa.i_tvalid = 1'b0; ifa.i_tlast = 1'b0; ifa.o_tready = 1'b1;
    ifb.i_tdata = '0; ifb.i_tvalid = 1'b0; ifb.i_tlast = 1'b0; ifb.o_tready = 1'b1;

    //             rnd  data           last chk  word           ns    olast
    vecs[0]  = '{1'b0, 32'h7FFF8000, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[1]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[2]  = '{1'b0, 32'hFFFF1234, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[3]  = '{1'b0, 32'h40004000, 1'b1, 1'b1, 32'h7800F144, 3'd4, 1'b1};
    vecs[4]  = '{1'b0, 32'h10002000, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[5]  = '{1'b0, 32'h30004000, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[6]  = '{1'b0, 32'h50006000, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[7]  = '{1'b0, 32'h70008000, 1'b0, 1'b1, 32'h12345678, 3'd4, 1'b0};
    vecs[8]  = '{1'b0, 32'h9000A000, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[9]  = '{1'b0, 32'hB000C000, 1'b1, 1'b1, 32'h9ABC0000, 3'd2, 1'b1};
    vecs[10] = '{1'b0, 32'hABCD1234, 1'b1, 1'b1, 32'hA1000000, 3'd1, 1'b1};
    vecs[11] = '{1'b1, 32'h0FFF7FFF, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[12] = '{1'b1, 32'h8000F7FF, 1'b1, 1'b1, 32'h178F0000, 3'd2, 1'b1};
    vecs[13] = '{1'b1, 32'h07FF0800, 1'b1, 1'b1, 32'h01000000, 3'd1, 1'b1};
    vecs[14] = '{1'b0, 32'h0008FFF7, 1'b1, 1'b1, 32'h0F000000, 3'd1, 1'b1};
    vecs[15] = '{1'b1, 32'hFF807800, 1'b1, 1'b1, 32'h07000000, 3'd1, 1'b1};

    #2;
    check("reset_state_trunc", {ifa.i_tready, ifa.o_tvalid, ifa.o_tlast, ifa.o_nsamp,
          ifa.o_tdata}, {1'b1, 37'd0});
    check("reset_state_round", {ifb.i_tready, ifb.o_tvalid, ifb.o_tlast, ifb.o_nsamp,
          ifb.o_tdata}, {1'b1, 37'd0});
    step();
    reset = 1'b0;
    step();

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rnd) begin
        ifb.i_tdata = vecs[i].d; ifb.i_tlast = vecs[i].last; ifb.i_tvalid = 1'b1;
      end else begin
        ifa.i_tdata = vecs[i].d; ifa.i_tlast = vecs[i].last; ifa.i_tvalid = 1'b1;
      end
      step();
      ifa.i_tvalid = 1'b0;
      ifb.i_tvalid = 1'b0;
      if (vecs[i].chk) begin
        if (vecs[i].rnd)
          check($sformatf("vec%0d_word", i), {ifb.o_tvalid, ifb.o_tlast, ifb.o_nsamp,
                ifb.o_tdata}, {1'b1, vecs[i].ol, vecs[i].ns, vecs[i].w});
        else
          check($sformatf("vec%0d_word", i), {ifa.o_tvalid, ifa.o_tlast, ifa.o_nsamp,
                ifa.o_tdata}, {1'b1, vecs[i].ol, vecs[i].ns, vecs[i].w});
      end else begin
        if (vecs[i].rnd) check($sformatf("vec%0d_novalid", i), ifb.o_tvalid, 0);
        else             check($sformatf("vec%0d_novalid", i), ifa.o_tvalid, 0);
      end
    end
    step();

    // Backpressure: fill one word with the output stalled, then hold for 10 cycles.
    ifa.o_tready = 1'b0;
    for (k = 0; k < 4; k++) begin
      ifa.i_tdata = bp_sample(k); ifa.i_tlast = 1'b0; ifa.i_tvalid = 1'b1;
      check("bp_fill_ready", ifa.i_tready, 1);
      step();
    end
    ifa.i_tdata = bp_sample(4);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold", {ifa.i_tready, ifa.o_tvalid, ifa.o_tdata}, {1'b0, 1'b1, bp_word(0)});
      step();
    end
    ifa.o_tready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (k < 16) begin
        ifa.i_tdata = bp_sample(k); ifa.i_tlast = (k == 15); ifa.i_tvalid = 1'b1;
      end else begin
        ifa.i_tvalid = 1'b0; ifa.i_tlast = 1'b0;
      end
      @(negedge clk);
      if (ifa.i_tvalid && ifa.i_tready) k++;
      if (ifa.o_tvalid && ifa.o_tready) begin
        got_w.push_back(ifa.o_tdata); got_c.push_back(c);
        got_l.push_back(ifa.o_tlast); got_n.push_back(ifa.o_nsamp);
      end
      step();
    end
    check("bp_words", got_w.size(), 4);
    check("bp_samples_taken", k, 16);
    for (int j = 0; j < got_w.size() && j < 4; j++) begin
      check($sformatf("bp_word%0d", j), {got_l[j], got_n[j], got_w[j]},
            {(j == 3), 3'd4, bp_word(j)});
      if (j > 0) check($sformatf("bp_gap%0d", j), got_c[j] - got_c[j-1], 4);
    end

    // Reset with a partial word in progress and a stale word in the output register.
    ifa.i_tdata = 32'h5555AAAA; ifa.i_tlast = 1'b1; ifa.i_tvalid = 1'b1;
    step();
    ifa.i_tdata = 32'h11112222; ifa.i_tlast = 1'b0;
    step();
    ifa.i_tdata = 32'h33334444;
    step();
    ifa.i_tvalid = 1'b0;
    check("pre_reset_stale", {ifa.o_tvalid, ifa.o_tlast, ifa.o_nsamp, ifa.o_tdata},
          {1'b0, 1'b1, 3'd1, 32'h5A000000});
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", {ifa.o_tvalid, ifa.o_tlast, ifa.o_nsamp, ifa.o_tdata}, 37'd0);
    step();
    step();
    reset = 1'b0;
    step();
    for (int s = 0; s < 4; s++) begin
      ifa.i_tdata  = {4'(2 * s + 2), 12'h000, 4'(2 * s + 3), 12'h000};
      ifa.i_tlast  = (s == 3);
      ifa.i_tvalid = 1'b1;
      step();
      if (s < 3) check($sformatf("post_reset_novalid%0d", s), ifa.o_tvalid, 0);
    end
    ifa.i_tvalid = 1'b0;
    check("post_reset_word", {ifa.o_tvalid, ifa.o_tlast, ifa.o_nsamp, ifa.o_tdata},
          {1'b1, 1'b1, 3'd4, 32'h23456789});
    step();

    // Parameter sweeps run concurrently.
    sweep_go = 1'b1;
    budget   = 0;
    all_done = 1'b0;
    while (!all_done && budget < 20000) begin
      step();
      budget++;
      all_done = g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done;
    end
    check("sweep_complete", all_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iq_sample_packer.md
# iq_sample_packer

Parametrised IQ sample compressor for the QPSK RFNoC datapath. It reduces each 32-bit complex sample (16-bit I in [31:16], 16-bit Q in [15:0]) to OUT_BITS bits per component, either by truncation or by rounding with saturation. It packs N = OUT_WIDTH/(2*OUT_BITS) reduced samples into each output word. Packets are honoured: a partial word is flushed zero-padded on input tlast. It sits between the sample-rate processing chain and the host-bound stream.

## Interface
- OUT_BITS, 4: bits kept per component; legal values 1, 2, 4, 8.
- OUT_WIDTH, 32: output word width; must be a multiple of 2*OUT_BITS, giving N = OUT_WIDTH/(2*OUT_BITS).
- ROUND, 0: reduction mode. 0 = truncate (keep the top OUT_BITS). 1 = round half-up with saturation.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- i_tdata  in  32  sample; I = [31:16], Q = [15:0], two's complement.
- i_tvalid  in  1  input valid.
- i_tlast  in  1  last sample of packet.
- i_tready  out  1  input ready.
- o_tdata  out  OUT_WIDTH  packed word.
- o_tvalid  out  1  output valid.
- o_tlast  out  1  word ends a packet.
- o_nsamp  out  clog2(N+1)  count of valid samples in o_tdata (1..N).
- o_tready  in  1  output ready.

## Operation
- **Reduction (ROUND=0):** r = x[15:16-OUT_BITS].
- **Reduction (ROUND=1):**
  - s = x + 2^(15-OUT_BITS), computed at 17 bits sign-extended.
  - If x ≥ 0 and s exceeds the max positive value: r = 0111…1.
  - Otherwise r = s[15:16-OUT_BITS].
  - Negative values never saturate.
- **Slot layout:**
  - Slot k (k = 0 is the first-accepted sample) occupies o_tdata[OUT_WIDTH-1-2*OUT_BITS*k -: 2*OUT_BITS].
  - Within a slot, I is in the upper OUT_BITS and Q in the lower OUT_BITS.
- **Accumulator:** an OUT_WIDTH register plus a slot counter `cnt`, range 0..N-1.
- **Accepting a beat** (i_tvalid & i_tready): the reduced slot is written at position `cnt`. The beat completes the word if cnt == N-1 or i_tlast = 1.
  - Completing beat: {accumulator with new slot, unused lower slots forced to 0} is loaded into the output register. Also loaded: o_tlast = i_tlast, o_nsamp = cnt+1, o_tvalid = 1. Then cnt → 0 and the accumulator clears.
  - Non-completing beat: cnt → cnt+1.
- **Input ready:** i_tready = ~o_tvalid | o_tready. Accumulating beats are also throttled by this rule. This keeps the design simple and costs no throughput when the output is drained.
- **Output register:** o_tdata, o_tlast and o_nsamp are stable while o_tvalid & ~o_tready.
  - o_tvalid clears on o_tready, unless the same cycle loads a new word; then it stays 1 with the new data.
- **Packets:**
  - Every input tlast produces exactly one output word with o_tlast = 1.
  - Packets never share an output word.
  - A 1-sample packet yields o_nsamp = 1, with slot 0 filled and all other slots zero.
- **Reset:** async assert clears o_tvalid, o_tlast, o_tdata, o_nsamp, cnt and the accumulator to 0. An in-progress partial word is discarded. Synchronous deassert is assumed from the reset synchroniser.

## Timing
- **Latency:** o_tvalid asserts the cycle after the completing input beat.
- **Throughput:** one input sample per clock while o_tready = 1, giving one output word per N clocks.
- **Backpressure:**
  - With o_tvalid = 1 and o_tready = 0, i_tready = 0 and no state changes.
  - i_tready is combinational from o_tvalid and o_tready; there is no i_tvalid → i_tready path.
- **Simultaneous drain and load:** o_tready = 1 with a completing beat in the same cycle is back-to-back; no bubble.
- **Counter wrap:** cnt wraps only through completion; cnt == N-1 with i_tlast = 1 is a single completion, not two.
- **Pipeline:** the reduction is combinational into the accumulator; no extra pipeline stage.

## Test plan
- **Truncation, ROUND=0, OUT_BITS=4:** samples 0x7FFF8000, 0x00000000, 0xFFFF1234, 0x40004000, tlast on the 4th beat → one word 0x7800F144 with o_nsamp = 4 and o_tlast = 1.
- **Rounding and saturation, ROUND=1, OUT_BITS=4:**
  - I = 0x0FFF → nibble 0x1 (truncation would give 0x0).
  - I = 0x7FFF → 0x7 (saturated).
  - I = 0x8000 → 0x8.
  - Q = 0xF7FF → 0xF.
- **Partial flush:** 6 samples, tlast on the 6th, OUT_BITS=4.
  - Word 1: o_nsamp = 4, o_tlast = 0.
  - Word 2: o_nsamp = 2, o_tlast = 1, lower 16 bits = 0x0000.
- **Backpressure:** o_tready held low for 10 cycles while o_tvalid = 1 → i_tready = 0 throughout and o_tdata stable. After release, a continuous stream gives one word every 4 cycles with no lost or duplicated samples (checked against a scoreboard).
- **Parameter sweep:** OUT_BITS = 1, 2, 8 with OUT_WIDTH = 32 (N = 16, 8, 2). Random packets of 1..40 samples with a random o_tready → the unpacked output matches the reference reduction, and the count of o_tlast words equals the count of input tlasts.
- **Reset mid-word:** assert reset after 2 of 4 samples → outputs are 0 immediately. After deassert, the next 4 samples form a clean word with o_nsamp = 4 and no residue from before reset.
